// File: rtl/fsm_almacen_n.sv
// N-bay storage controller: each bay runs an independent Moore FSM that pulses
// the entry (A) or exit (C) actuator for HOLD cycles and keeps an item count.
module fsm_almacen_n #(
  parameter int N    = 4,
  parameter int CAP  = 15,
  parameter int HOLD = 2,
  parameter int TW   = $clog2(N * CAP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   S1,
  input  logic [N-1:0]   S2,
  input  logic           clr_err,
  output logic [N-1:0]   A,
  output logic [N-1:0]   C,
  output logic [N-1:0]   FULL,
  output logic [N-1:0]   EMPTY,
  output logic [N-1:0]   ERR,
  output logic [TW-1:0]  TOTAL,
  output logic [2*N-1:0] dbg_state
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [7:0]    CAP8      = 8'(CAP);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IN    = 2'd1,
    OUT   = 2'd2,
    BLOCK = 2'd3
  } state_t;

  state_t        state_q [N];
  state_t        state_d [N];
  logic [HW-1:0] timer_q [N];
  logic [HW-1:0] timer_d [N];
  logic [7:0]    count_q [N];
  logic [7:0]    count_d [N];
  logic [N-1:0]  s1_prev_q, s2_prev_q;
  logic [N-1:0]  err_q, err_d, err_set;
  logic [N-1:0]  rise1, rise2;

  assign rise1 = S1 & ~s1_prev_q;
  assign rise2 = S2 & ~s2_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
        count_q[i] <= '0;
      end
      s1_prev_q <= '0;
      s2_prev_q <= '0;
      err_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        count_q[i] <= count_d[i];
      end
      s1_prev_q <= S1;
      s2_prev_q <= S2;
      err_q     <= err_d;
    end
  end

  always_comb begin
    err_set = '0;
    err_d   = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      count_d[i] = count_q[i];
      case (state_q[i])
        IDLE: begin
          // Entry wins a simultaneous rise; the dropped exit is flagged.
          if (rise1[i]) begin
            if (rise2[i]) err_set[i] = 1'b1;
            if (count_q[i] < CAP8) begin
              state_d[i] = IN;
              timer_d[i] = HOLD_LAST;
            end else begin
              state_d[i] = BLOCK;
              err_set[i] = 1'b1;
            end
          end else if (rise2[i]) begin
            if (count_q[i] != 8'd0) begin
              state_d[i] = OUT;
              timer_d[i] = HOLD_LAST;
            end else begin
              err_set[i] = 1'b1;
            end
          end
        end
        IN: begin
          if (timer_q[i] == '0) begin
            state_d[i] = IDLE;
            count_d[i] = count_q[i] + 8'd1;
          end else begin
            timer_d[i] = timer_q[i] - HW'(1);
          end
        end
        OUT: begin
          if (timer_q[i] == '0) begin
            state_d[i] = IDLE;
            count_d[i] = count_q[i] - 8'd1;
          end else begin
            timer_d[i] = timer_q[i] - HW'(1);
          end
        end
        BLOCK: begin
          if (!S1[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
      // A new error in the same cycle outranks the clear.
      err_d[i] = err_set[i] ? 1'b1 : (clr_err ? 1'b0 : err_q[i]);
    end
  end

  always_comb begin
    A         = '0;
    C         = '0;
    FULL      = '0;
    EMPTY     = '0;
    TOTAL     = '0;
    dbg_state = '0;
    for (int i = 0; i < N; i++) begin
      A[i]              = (state_q[i] == IN);
      C[i]              = (state_q[i] == OUT);
      FULL[i]           = (count_q[i] == CAP8);
      EMPTY[i]          = (count_q[i] == 8'd0);
      TOTAL             = TOTAL + TW'(count_q[i]);
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_fsm_almacen_n.sv
// Directed bench for fsm_almacen_n with N=4, CAP=3, HOLD=2.
module tb_fsm_almacen_n;

  localparam int N = 4;
  localparam int CAP = 3;
  localparam int HOLD = 2;
  localparam int TW = $clog2(N * CAP + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   S1 = '0;
  logic [N-1:0]   S2 = '0;
  logic           clr_err = 1'b0;
  logic [N-1:0]   A, C, FULL, EMPTY, ERR;
  logic [TW-1:0]  TOTAL;
  logic [2*N-1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  fsm_almacen_n #(.N(N), .CAP(CAP), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .S1(S1), .S2(S2), .clr_err(clr_err),
    .A(A), .C(C), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR),
    .TOTAL(TOTAL), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_s1(input int b);
    S1[b] = 1'b1;
    tick(1);
    S1[b] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (A !== 4'b0000) begin failures++; $display("FAIL reset_A got=%b exp=0000", A); end
    checks++; if (C !== 4'b0000) begin failures++; $display("FAIL reset_C got=%b exp=0000", C); end
    checks++; if (FULL !== 4'b0000) begin failures++; $display("FAIL reset_FULL got=%b exp=0000", FULL); end
    checks++; if (EMPTY !== 4'b1111) begin failures++; $display("FAIL reset_EMPTY got=%b exp=1111", EMPTY); end
    checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL reset_ERR got=%b exp=0000", ERR); end
    checks++; if (TOTAL !== 4'd0) begin failures++; $display("FAIL reset_TOTAL got=%0d exp=0", TOTAL); end
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_entry;
    int a_cycles = 0;
    int first = -1;
    S1 = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) S1 = 4'b0000;
      tick(1);
      if (A[0]) begin
        a_cycles++;
        if (first < 0) first = i;
      end
    end
    checks++; if (a_cycles != 2) begin failures++; $display("FAIL entry_A_len got=%0d exp=2", a_cycles); end
    checks++; if (first != 0) begin failures++; $display("FAIL entry_A_latency got=%0d exp=0", first); end
    checks++; if (EMPTY[0] !== 1'b0) begin failures++; $display("FAIL entry_EMPTY0 got=%b exp=0", EMPTY[0]); end
    checks++; if (TOTAL !== 4'd1) begin failures++; $display("FAIL entry_TOTAL got=%0d exp=1", TOTAL); end
  endtask

  task automatic test_fill;
    int a_seen = 0;
    for (int p = 1; p <= 3; p++) begin
      pulse_s1(1);
      checks++; if (TOTAL !== TW'(1 + p)) begin failures++; $display("FAIL fill_TOTAL_%0d got=%0d exp=%0d", p, TOTAL, 1 + p); end
      checks++; if (FULL[1] !== (p == 3)) begin failures++; $display("FAIL fill_FULL_%0d got=%b exp=%b", p, FULL[1], p == 3); end
    end
    S1[1] = 1'b1;
    tick(1);
    if (A[1]) a_seen++;
    checks++; if (dbg_state[3:2] !== 2'd3) begin failures++; $display("FAIL fill_BLOCK got=%0d exp=3", dbg_state[3:2]); end
    checks++; if (ERR[1] !== 1'b1) begin failures++; $display("FAIL fill_ERR1 got=%b exp=1", ERR[1]); end
    S1[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (A[1]) a_seen++;
    end
    checks++; if (a_seen != 0) begin failures++; $display("FAIL fill_A1_blocked got=%0d exp=0", a_seen); end
    checks++; if (dbg_state[3:2] !== 2'd0) begin failures++; $display("FAIL fill_unblock got=%0d exp=0", dbg_state[3:2]); end
    checks++; if (TOTAL !== 4'd4) begin failures++; $display("FAIL fill_TOTAL_final got=%0d exp=4", TOTAL); end
  endtask

  task automatic test_exit_empty;
    int c_seen = 0;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL clr_all got=%b exp=0000", ERR); end
    S2[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (C[2]) c_seen++;
    end
    S2[2] = 1'b0;
    checks++; if (c_seen != 0) begin failures++; $display("FAIL empty_exit_C2 got=%0d exp=0", c_seen); end
    checks++; if (ERR !== 4'b0100) begin failures++; $display("FAIL empty_exit_ERR got=%b exp=0100", ERR); end
    checks++; if (EMPTY[2] !== 1'b1) begin failures++; $display("FAIL empty_exit_EMPTY2 got=%b exp=1", EMPTY[2]); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL clr_err2 got=%b exp=0000", ERR); end
  endtask

  task automatic test_simultaneous;
    int c_cycles = 0;
    pulse_s1(3);
    checks++; if (TOTAL !== 4'd5) begin failures++; $display("FAIL sim_pre_TOTAL got=%0d exp=5", TOTAL); end
    S1[3] = 1'b1;
    S2[3] = 1'b1;
    tick(1);
    S1[3] = 1'b0;
    S2[3] = 1'b0;
    checks++; if (A[3] !== 1'b1) begin failures++; $display("FAIL sim_A3 got=%b exp=1", A[3]); end
    checks++; if (C[3] !== 1'b0) begin failures++; $display("FAIL sim_C3 got=%b exp=0", C[3]); end
    checks++; if (ERR !== 4'b1000) begin failures++; $display("FAIL sim_ERR got=%b exp=1000", ERR); end
    tick(2);
    checks++; if (TOTAL !== 4'd6) begin failures++; $display("FAIL sim_TOTAL got=%0d exp=6", TOTAL); end
    S2[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) S2[3] = 1'b0;
      tick(1);
      if (C[3]) c_cycles++;
    end
    checks++; if (c_cycles != 2) begin failures++; $display("FAIL exit_C3_len got=%0d exp=2", c_cycles); end
    checks++; if (TOTAL !== 4'd5) begin failures++; $display("FAIL exit_TOTAL got=%0d exp=5", TOTAL); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic test_back_to_back;
    S1 = 4'b0101;
    tick(1);
    checks++; if (A !== 4'b0101) begin failures++; $display("FAIL b2b_A_first got=%b exp=0101", A); end
    S1 = 4'b0000;
    S2 = 4'b0001;
    tick(1);
    checks++; if (A !== 4'b0101) begin failures++; $display("FAIL b2b_A_second got=%b exp=0101", A); end
    tick(1);
    checks++; if (A !== 4'b0000) begin failures++; $display("FAIL b2b_A_done got=%b exp=0000", A); end
    checks++; if (TOTAL !== 4'd7) begin failures++; $display("FAIL b2b_TOTAL got=%0d exp=7", TOTAL); end
    tick(1);
    checks++; if (C !== 4'b0000) begin failures++; $display("FAIL b2b_ignored_C got=%b exp=0000", C); end
    checks++; if (ERR !== 4'b0000) begin failures++; $display("FAIL b2b_ignored_ERR got=%b exp=0000", ERR); end
    S2 = 4'b0000;
    tick(1);
  endtask

  task automatic test_reset_mid;
    S1[0] = 1'b1;
    tick(1);
    S1[0] = 1'b0;
    checks++; if (A[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_A0 got=%b exp=1", A[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (A !== 4'b0000) begin failures++; $display("FAIL rst_mid_A got=%b exp=0000", A); end
    checks++; if (TOTAL !== 4'd0) begin failures++; $display("FAIL rst_mid_TOTAL got=%0d exp=0", TOTAL); end
    checks++; if (EMPTY !== 4'b1111) begin failures++; $display("FAIL rst_mid_EMPTY got=%b exp=1111", EMPTY); end
    tick(1);
    S1 = 4'b0010;
    rst = 1'b0;
    tick(1);
    checks++; if (A !== 4'b0010) begin failures++; $display("FAIL post_rst_rise got=%b exp=0010", A); end
    S1 = 4'b0000;
    tick(3);
    checks++; if (TOTAL !== 4'd1) begin failures++; $display("FAIL post_rst_TOTAL got=%0d exp=1", TOTAL); end
  endtask

  initial begin
    test_reset;
    test_single_entry;
    test_fill;
    test_exit_empty;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
